// File: rtl/gate_sweep_pkg.sv
// Shared types and the reference gate function for the
// exhaustive gate sweep checker.
package gate_sweep_pkg;

  localparam logic [1:0] MODE_NOR  = 2'b00;
  localparam logic [1:0] MODE_NAND = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  // vec is zero-extended to 8 bits; n says how many bits are real.
  function automatic logic expected_out(
    input logic [1:0] mode,
    input logic [7:0] vec,
    input int         n
  );
    logic [7:0] m;
    logic       r;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i < n) m[i] = 1'b1;
    unique case (mode)
      MODE_NOR:  r = ~|(vec & m);
      MODE_NAND: r = ~&(vec | ~m);
      MODE_XOR:  r = ^(vec & m);
      default:   r = ~^(vec & m);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational reference gate; a thin wrapper so the
// expected-value source can be swapped out.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [1:0]      mode,
  input  logic [N_IN-1:0] vec,
  output logic            exp
);

  assign exp = expected_out(mode, 8'(vec), N_IN);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep driver and self-checker for an N-input
// single-output gate under test.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dut_out,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  localparam int CW =
    (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CLAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VLAST = '1;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  mode_q;
  logic        exp_bit;
  logic        mismatch;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .mode (mode_q),
    .vec  (stim),
    .exp  (exp_bit)
  );

  assign mismatch = dut_out != exp_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      mode_q         <= MODE_NOR;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= DRIVE;
            cnt            <= '0;
            mode_q         <= mode;
            stim           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        DRIVE: begin
          if (cnt == CLAST) begin
            if (mismatch) begin
              if (!(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
              if (!fail_valid) begin
                first_fail_vec <= stim;
                fail_valid     <= 1'b1;
              end
            end
            // pass must include this final compare
            if (stim == VLAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mismatch && (err_cnt == '0);
            end else begin
              stim <= stim + 1'b1;
              cnt  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
